// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access controller and its response
// serializer: FSM state encodings, response status bytes, command codes
// (shared with the UART command decoder) and frame-length constants.
package mem_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_WAIT,
        ERR,
        TX_LOAD,
        TX_ACK,
        TX_WAIT,
        DONE
    } state_t;

    localparam logic [7:0] STAT_READ     = 8'hA1;
    localparam logic [7:0] STAT_WRITE    = 8'hA2;
    localparam logic [7:0] STAT_ERR_BASE = 8'hE0;

    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    // Frame lengths in bytes: status + 4 data bytes for reads, status only otherwise.
    localparam logic [2:0] LEN_READ  = 3'd5;
    localparam logic [2:0] LEN_SHORT = 3'd1;

    function automatic logic [7:0] err_status(input logic [2:0] err);
        return STAT_ERR_BASE | {5'b00000, err};
    endfunction

endpackage

// File: rtl/resp_serializer.sv
// Streams a response frame (up to 5 bytes, byte 0 first) to a byte-wide
// UART transmitter using a start/busy handshake.
//   clock, reset   : system clock, synchronous active-low reset
//   i_load         : one-cycle pulse, capture i_len/i_frame and begin sending
//   i_len          : number of bytes in the frame (1..5)
//   i_frame        : frame contents, byte 0 in bits 7:0
//   i_tx_busy      : transmitter busy
//   o_tx_byte      : byte presented to the transmitter
//   o_tx_start     : one-cycle start pulse to the transmitter
//   o_done         : one-cycle pulse once the last byte has been sent
module resp_serializer
    import mem_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        i_load,
    input  logic [2:0]  i_len,
    input  logic [39:0] i_frame,
    input  logic        i_tx_busy,
    output logic [7:0]  o_tx_byte,
    output logic        o_tx_start,
    output logic        o_done
);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;     // index of the byte currently on o_tx_byte
    logic [2:0]  len_q, len_d;
    logic [39:0] shift_q, shift_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        shift_d    = shift_q;
        o_tx_start = 1'b0;
        o_done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_load) begin
                    shift_d = i_frame;
                    len_d   = i_len;
                    cnt_d   = '0;
                    state_d = TX_LOAD;
                end
            end
            TX_LOAD: begin
                if (!i_tx_busy) begin
                    o_tx_start = 1'b1;
                    state_d    = TX_ACK;
                end
            end
            // Wait for the transmitter to acknowledge the start before
            // watching for the end of the byte.
            TX_ACK: begin
                if (i_tx_busy) state_d = TX_WAIT;
            end
            TX_WAIT: begin
                if (!i_tx_busy) begin
                    if (cnt_q == len_q - 3'd1) begin
                        o_done  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 3'd1;
                        shift_d = {8'h00, shift_q[39:8]};
                        state_d = TX_LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The low byte of the shift register is the byte on the wire; it only
    // changes when the next byte is shifted in or a new frame is loaded.
    assign o_tx_byte = shift_q[7:0];

endmodule

// File: rtl/mem_access_controller.sv
// Sequences decoded UART commands into a single-port BRAM (one write or one
// read per command) and streams a response frame to uart_tx.
//   clock, reset      : system clock, synchronous active-low reset
//   i_done            : one-cycle pulse, decoded request valid
//   i_readwrite       : 1 = read, 0 = write
//   i_address/i_data  : word address / write data (byte 0 = bits 7:0)
//   i_error           : decoder error code, nonzero = failed command
//   o_mem_*           : BRAM port (enable, write enable, address, write data)
//   i_mem_rdata       : BRAM read data, valid READ_LATENCY cycles after enable
//   o_tx_byte/o_tx_start/i_tx_busy : uart_tx interface
//   o_busy            : high whenever an operation is in progress
//   o_dropped         : one-cycle pulse, a request arrived while busy
module mem_access_controller
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = 15,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int ACK_WRITE    = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_done,
    input  logic                  i_readwrite,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [2:0]            i_error,
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic [7:0]            o_tx_byte,
    output logic                  o_tx_start,
    input  logic                  i_tx_busy,
    output logic                  o_busy,
    output logic                  o_dropped
);

    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY);

    state_t                state_q, state_d;
    logic                  rw_q, rw_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [2:0]            err_q, err_d;
    logic [1:0]            lat_q, lat_d;
    logic                  drop_q;

    logic                  ser_load;
    logic [2:0]            ser_len;
    logic [DATA_WIDTH+7:0] ser_frame;
    logic                  ser_done;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= '0;
            lat_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
            lat_q   <= lat_d;
            // Anything outside IDLE, including the DONE cycle, rejects requests.
            drop_q  <= i_done && (state_q != IDLE);
        end
    end

    always_comb begin
        state_d   = state_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        data_d    = data_q;
        err_d     = err_q;
        lat_d     = lat_q;
        o_mem_en  = 1'b0;
        o_mem_we  = 1'b0;
        ser_load  = 1'b0;
        ser_len   = LEN_SHORT;
        ser_frame = {{DATA_WIDTH{1'b0}}, STAT_WRITE};
        case (state_q)
            IDLE: begin
                if (i_done) begin
                    rw_d   = i_readwrite;
                    addr_d = i_address;
                    data_d = i_data;
                    err_d  = i_error;
                    if (i_error != 3'd0)  state_d = ERR;
                    else if (i_readwrite) state_d = RD_ISSUE;
                    else                  state_d = WR;
                end
            end
            WR: begin
                o_mem_en = 1'b1;
                o_mem_we = 1'b1;
                if (ACK_WRITE != 0) begin
                    ser_load = 1'b1;
                    state_d  = TX_WAIT;
                end else begin
                    state_d  = DONE;
                end
            end
            RD_ISSUE: begin
                o_mem_en = 1'b1;
                lat_d    = '0;
                state_d  = RD_WAIT;
            end
            // Count out READ_LATENCY cycles, then take the data on the
            // following cycle; the BRAM output holds until its next enable.
            RD_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    ser_load  = 1'b1;
                    ser_len   = LEN_READ;
                    ser_frame = {i_mem_rdata, STAT_READ};
                    state_d   = TX_WAIT;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            ERR: begin
                ser_load  = 1'b1;
                ser_frame = {{DATA_WIDTH{1'b0}}, err_status(err_q)};
                state_d   = TX_WAIT;
            end
            // The serializer owns the frame while the main FSM parks here.
            TX_WAIT: begin
                if (ser_done) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    resp_serializer u_ser (
        .clock      (clock),
        .reset      (reset),
        .i_load     (ser_load),
        .i_len      (ser_len),
        .i_frame    (ser_frame),
        .i_tx_busy  (i_tx_busy),
        .o_tx_byte  (o_tx_byte),
        .o_tx_start (o_tx_start),
        .o_done     (ser_done)
    );

    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = data_q;
    assign o_busy      = (state_q != IDLE);
    assign o_dropped   = drop_q;

endmodule

// File: tb/tb_mem_access_controller.sv
module tb_mem_access_controller;

    localparam int RL = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        i_done = 1'b0;
    logic        i_readwrite = 1'b0;
    logic [14:0] i_address = '0;
    logic [31:0] i_data = '0;
    logic [2:0]  i_error = '0;
    logic        o_mem_en, o_mem_we;
    logic [14:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic [7:0]  o_tx_byte;
    logic        o_tx_start;
    logic        i_tx_busy;
    logic        o_busy, o_dropped;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    mem_access_controller #(
        .ADDR_WIDTH(15), .DATA_WIDTH(32), .READ_LATENCY(RL), .ACK_WRITE(1)
    ) dut (
        .clock(clock), .reset(reset), .i_done(i_done), .i_readwrite(i_readwrite),
        .i_address(i_address), .i_data(i_data), .i_error(i_error),
        .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
        .o_tx_byte(o_tx_byte), .o_tx_start(o_tx_start), .i_tx_busy(i_tx_busy),
        .o_busy(o_busy), .o_dropped(o_dropped)
    );

    // BRAM model: read data appears RL cycles after the enable and holds.
    bit [31:0] bram [0:32767];
    bit [31:0] rd_pipe [1:3];
    always @(posedge clock) begin
        if (o_mem_en && o_mem_we) bram[o_mem_addr] <= o_mem_wdata;
        if (o_mem_en && !o_mem_we) rd_pipe[1] <= bram[o_mem_addr];
        rd_pipe[2] <= rd_pipe[1];
        rd_pipe[3] <= rd_pipe[2];
    end
    assign i_mem_rdata = rd_pipe[RL];

    // UART model: busy rises the cycle after a start and lasts tx_len cycles.
    logic uart_busy = 1'b0;
    int   uart_cnt  = 0;
    int   tx_len    = 3;
    logic hold_busy = 1'b0;
    always @(posedge clock) begin
        if (!reset) begin
            uart_busy <= 1'b0;
            uart_cnt  <= 0;
        end else if (o_tx_start) begin
            uart_busy <= 1'b1;
            uart_cnt  <= tx_len;
        end else if (uart_busy) begin
            if (uart_cnt <= 1) uart_busy <= 1'b0;
            uart_cnt <= uart_cnt - 1;
        end
    end
    assign i_tx_busy = uart_busy | hold_busy;

    // Monitor
    typedef struct packed {logic we; logic [14:0] addr; logic [31:0] wdata;} acc_t;
    logic [7:0] txq[$];
    acc_t       memq[$];
    int         drops = 0;
    always @(negedge clock) begin
        if (o_tx_start) txq.push_back(o_tx_byte);
        if (o_mem_en) memq.push_back({o_mem_we, o_mem_addr, o_mem_wdata});
        if (o_dropped) drops++;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear();
        txq.delete();
        memq.delete();
        drops = 0;
    endtask

    task automatic send(input logic rw, input logic [14:0] a, input logic [31:0] d,
                        input logic [2:0] e);
        @(posedge clock); #1;
        i_done = 1'b1; i_readwrite = rw; i_address = a; i_data = d; i_error = e;
        @(posedge clock); #1;
        i_done = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (o_busy && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check($sformatf("%s idle in time", nm), o_busy, 1'b0);
    endtask

    task automatic check_frame(input string nm, input int n, input logic [39:0] f);
        logic [7:0] a;
        check($sformatf("%s frame length", nm), txq.size(), n);
        for (int i = 0; i < n; i++) begin
            a = (i < txq.size()) ? txq[i] : 8'hxx;
            check($sformatf("%s byte%0d", nm, i), a, f[8*i +: 8]);
        end
    endtask

    task automatic check_acc(input string nm, input int n, input logic we,
                             input logic [14:0] a, input logic [31:0] d);
        check($sformatf("%s bram accesses", nm), memq.size(), n);
        if (n > 0 && memq.size() > 0) begin
            check($sformatf("%s bram we", nm), memq[0].we, we);
            check($sformatf("%s bram addr", nm), memq[0].addr, a);
            if (we) check($sformatf("%s bram wdata", nm), memq[0].wdata, d);
        end
    endtask

    typedef struct {
        logic        rw;
        logic [14:0] addr;
        logic [31:0] data;
        logic [2:0]  err;
        int          nb;
        logic [39:0] frame;
        int          nacc;
    } vec_t;
    vec_t tbl[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] f;
        logic [2:0]  st;
        int          n;
        bit [31:0]   ref_mem [0:7];

        tbl[0] = '{1'b0, 15'h0123, 32'hDEADBEEF, 3'd0, 1, 40'hA2, 1};
        tbl[1] = '{1'b1, 15'h0123, 32'h0,        3'd0, 5, 40'hDEADBEEF_A1, 1};
        tbl[2] = '{1'b1, 15'h0123, 32'h0,        3'd2, 1, 40'hE2, 0};
        tbl[3] = '{1'b0, 15'h7FFF, 32'h00000001, 3'd0, 1, 40'hA2, 1};
        tbl[4] = '{1'b1, 15'h7FFF, 32'h0,        3'd0, 5, 40'h00000001_A1, 1};
        tbl[5] = '{1'b0, 15'h0010, 32'h55555555, 3'd7, 1, 40'hE7, 0};
        tbl[6] = '{1'b1, 15'h0000, 32'h0,        3'd0, 5, 40'h00000000_A1, 1};

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset mem outputs", {o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata}, '0);
        check("reset tx/status outputs", {o_tx_byte, o_tx_start, o_busy, o_dropped}, '0);
        reset = 1'b1;
        clear();

        // Table-driven vectors
        for (int v = 0; v < 7; v++) begin
            clear();
            send(tbl[v].rw, tbl[v].addr, tbl[v].data, tbl[v].err);
            wait_idle($sformatf("vec%0d", v));
            check_frame($sformatf("vec%0d", v), tbl[v].nb, tbl[v].frame);
            check_acc($sformatf("vec%0d", v), tbl[v].nacc, ~tbl[v].rw, tbl[v].addr, tbl[v].data);
            check($sformatf("vec%0d drops", v), drops, 0);
        end

        // Write latency: we at +1, first start at +2
        clear();
        send(1'b0, 15'h0055, 32'hCAFEF00D, 3'd0);
        @(negedge clock);
        check("wr lat en/we at +1", {o_mem_en, o_mem_we}, 2'b11);
        check("wr lat addr", o_mem_addr, 15'h0055);
        check("wr lat wdata", o_mem_wdata, 32'hCAFEF00D);
        @(negedge clock);
        check("wr lat start at +2", {o_tx_start, o_tx_byte}, {1'b1, 8'hA2});
        wait_idle("wr lat");
        check_frame("wr lat", 1, 40'hA2);

        // Read latency: en at +1, first start at +2+RL+1
        clear();
        send(1'b1, 15'h0055, 32'h0, 3'd0);
        @(negedge clock);
        check("rd lat en/we at +1", {o_mem_en, o_mem_we}, 2'b10);
        st = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            st[i] = o_tx_start;
        end
        check("rd lat start pattern +2..+4", st, 3'b100);
        wait_idle("rd lat");
        check_frame("rd lat", 5, 40'hCAFEF00D_A1);

        // Drop: new request during read frame byte 2
        clear();
        send(1'b1, 15'h0123, 32'h0, 3'd0);
        n = 0;
        while (txq.size() < 3 && n < 500) begin @(negedge clock); n++; end
        check("drop reached byte 2", txq.size() >= 3, 1'b1);
        send(1'b0, 15'h0200, 32'h12345678, 3'd0);
        wait_idle("drop");
        check("drop pulses", drops, 1);
        check_frame("drop", 5, 40'hDEADBEEF_A1);
        check_acc("drop", 1, 1'b0, 15'h0123, 32'h0);

        // Reset mid-frame after the second byte starts
        clear();
        send(1'b1, 15'h0123, 32'h0, 3'd0);
        n = 0;
        while (txq.size() < 2 && n < 500) begin @(negedge clock); n++; end
        check("rst reached byte 1", txq.size(), 2);
        reset = 1'b0;
        @(negedge clock);
        check("rst mid mem outputs", {o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata}, '0);
        check("rst mid tx/status outputs", {o_tx_byte, o_tx_start, o_busy, o_dropped}, '0);
        reset = 1'b1;
        repeat (30) @(negedge clock);
        check("rst no further start", txq.size(), 2);
        clear();
        send(1'b0, 15'h0042, 32'h11223344, 3'd0);
        wait_idle("post rst write");
        check_frame("post rst write", 1, 40'hA2);
        check_acc("post rst write", 1, 1'b1, 15'h0042, 32'h11223344);

        // Back-pressure before the first byte
        clear();
        hold_busy = 1'b1;
        send(1'b0, 15'h0300, 32'hA5A55A5A, 3'd0);
        repeat (50) @(negedge clock);
        check("bp start withheld", txq.size(), 0);
        check("bp still busy", o_busy, 1'b1);
        hold_busy = 1'b0;
        wait_idle("bp");
        check_frame("bp", 1, 40'hA2);
        check_acc("bp", 1, 1'b1, 15'h0300, 32'hA5A55A5A);

        // Randomized requests against a reference model
        for (int k = 0; k < 8; k++) ref_mem[k] = '0;
        for (int it = 0; it < 40; it++) begin
            logic        rw;
            int          ai;
            logic [31:0] d;
            logic [2:0]  e;
            tx_len = $urandom_range(1, 6);
            rw = 1'($urandom % 2);
            ai = int'($urandom % 8);
            d  = $urandom;
            e  = ($urandom % 5 == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            clear();
            send(rw, 15'h0100 + 15'(ai), d, e);
            wait_idle($sformatf("rnd%0d", it));
            if (e != 0) begin
                check_frame($sformatf("rnd%0d err", it), 1, {32'h0, 8'hE0 + 8'(e)});
                check_acc($sformatf("rnd%0d err", it), 0, 1'b0, 15'h0, 32'h0);
            end else if (!rw) begin
                ref_mem[ai] = d;
                check_frame($sformatf("rnd%0d wr", it), 1, 40'hA2);
                check_acc($sformatf("rnd%0d wr", it), 1, 1'b1, 15'h0100 + 15'(ai), d);
            end else begin
                f = {ref_mem[ai], 8'hA1};
                check_frame($sformatf("rnd%0d rd", it), 5, f);
                check_acc($sformatf("rnd%0d rd", it), 1, 1'b0, 15'h0100 + 15'(ai), 32'h0);
            end
            repeat ($urandom % 3) @(negedge clock);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
